// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - E-stage MDU front end: issue handshake, HI/LO registers, pipeline stall
module hilo_ctrl #(
  parameter logic [31:0] RESET_HI = 32'h0,
  parameter logic [31:0] RESET_LO = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        e_flush,
  output logic        md_stall,
  output logic [31:0] md_rdata,
  output logic        md_busy,
  output logic [31:0] mdu_src0,
  output logic [31:0] mdu_src1,
  output logic [1:0]  mdu_op,
  output logic        mdu_sign,
  output logic        mdu_in_valid,
  input  logic        mdu_in_ready,
  output logic        mdu_out_ready,
  input  logic        mdu_out_valid,
  input  logic [31:0] mdu_res0,
  input  logic [31:0] mdu_res1
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  localparam logic [1:0] MDU_IDLE = 2'b00;
  localparam logic [1:0] MDU_MUL  = 2'b01;
  localparam logic [1:0] MDU_DIV  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic is_mul;
  logic is_div;
  logic start;
  logic use_md;

  // Classify the E-stage instruction; a flushed mult/div never starts
  always_comb begin
    is_mul = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
    is_div = (e_md_op == OP_DIV)  || (e_md_op == OP_DIVU);
    start  = (is_mul || is_div) && !e_flush;
    use_md = (e_md_op != OP_NONE);
  end

  // FSM next state, HI/LO next values, MDU handshake and stall generation
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    mdu_in_valid  = 1'b0;
    mdu_out_ready = 1'b0;
    mdu_op        = MDU_IDLE;
    mdu_sign      = 1'b0;
    md_stall      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mdu_in_valid = start;
        if (start) begin
          mdu_op   = is_mul ? MDU_MUL : MDU_DIV;
          mdu_sign = (e_md_op == OP_MULT) || (e_md_op == OP_DIV);
          // The issuing instruction itself only waits when the MDU refuses it
          if (mdu_in_ready) begin
            state_d = ST_BUSY;
          end else begin
            md_stall = 1'b1;
          end
        end
        // Direct HI/LO writes only happen here, so they can never collide
        // with a result write-back in BUSY
        if (!e_flush) begin
          if (e_md_op == OP_MTHI) begin
            hi_d = e_rs;
          end
          if (e_md_op == OP_MTLO) begin
            lo_d = e_rs;
          end
        end
      end
      ST_BUSY: begin
        mdu_out_ready = 1'b1;
        // No result bypass: any MDU-class instruction waits until HI/LO
        // hold the new result, including the cycle the result arrives
        md_stall = use_md;
        // An in-flight op belongs to a committed instruction, so e_flush is
        // deliberately ignored here
        if (mdu_out_valid) begin
          hi_d    = mdu_res1;
          lo_d    = mdu_res0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Combinational read port for mfhi/mflo and pass-through outputs
  always_comb begin
    md_rdata = 32'h0;
    if (e_md_op == OP_MFHI) begin
      md_rdata = hi_q;
    end else if (e_md_op == OP_MFLO) begin
      md_rdata = lo_q;
    end
    md_busy  = (state_q == ST_BUSY);
    mdu_src0 = e_rs;
    mdu_src1 = e_rt;
  end

  // State and architectural HI/LO registers; reset drops any in-flight op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hi_q    <= RESET_HI;
      lo_q    <= RESET_LO;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb/tb_hilo_ctrl.sv - scoreboard bench for hilo_ctrl with a behavioural MDU responder
module tb_hilo_ctrl;

  localparam logic [31:0] RST_HI = 32'hA5A5_0001;
  localparam logic [31:0] RST_LO = 32'h5A5A_0002;

  logic        clk;
  logic        reset;
  logic [3:0]  e_md_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        e_flush;
  logic        md_stall;
  logic [31:0] md_rdata;
  logic        md_busy;
  logic [31:0] mdu_src0;
  logic [31:0] mdu_src1;
  logic [1:0]  mdu_op;
  logic        mdu_sign;
  logic        mdu_in_valid;
  logic        mdu_in_ready;
  logic        mdu_out_ready;
  logic        mdu_out_valid;
  logic [31:0] mdu_res0;
  logic [31:0] mdu_res1;

  hilo_ctrl #(.RESET_HI(RST_HI), .RESET_LO(RST_LO)) dut (
    .clk(clk), .reset(reset),
    .e_md_op(e_md_op), .e_rs(e_rs), .e_rt(e_rt), .e_flush(e_flush),
    .md_stall(md_stall), .md_rdata(md_rdata), .md_busy(md_busy),
    .mdu_src0(mdu_src0), .mdu_src1(mdu_src1), .mdu_op(mdu_op), .mdu_sign(mdu_sign),
    .mdu_in_valid(mdu_in_valid), .mdu_in_ready(mdu_in_ready),
    .mdu_out_ready(mdu_out_ready), .mdu_out_valid(mdu_out_valid),
    .mdu_res0(mdu_res0), .mdu_res1(mdu_res1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Expected issue record: {mdu_op, mdu_sign, src0, src1}
  logic [66:0] issue_q[$];
  logic [31:0] read_q[$];

  // Responder configuration for the next accepted op
  int          lat_cfg    = 1;
  logic [31:0] r0_cfg     = '0;
  logic [31:0] r1_cfg     = '0;
  int          ready_hold = 0;

  task automatic check(input string name, input logic [66:0] got, input logic [66:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Behavioural MDU: samples handshakes at negedge, updates outputs 2 time units after posedge
  initial begin : mdu_model
    bit acc, fin, pend;
    int cnt;
    mdu_in_ready  = 1'b1;
    mdu_out_valid = 1'b0;
    mdu_res0      = '0;
    mdu_res1      = '0;
    pend = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      acc = mdu_in_valid && mdu_in_ready && !reset;
      fin = mdu_out_valid && mdu_out_ready && !reset;
      @(posedge clk);
      #2;
      if (reset) begin
        pend = 1'b0;
        cnt = 0;
        mdu_out_valid = 1'b0;
        mdu_in_ready = 1'b1;
      end else begin
        if (fin) begin
          mdu_out_valid = 1'b0;
          pend = 1'b0;
        end
        if (acc) begin
          pend = 1'b1;
          cnt = lat_cfg;
        end
        if (pend && !mdu_out_valid) begin
          cnt--;
          if (cnt <= 0) begin
            mdu_out_valid = 1'b1;
            mdu_res0 = r0_cfg;
            mdu_res1 = r1_cfg;
          end
        end
        if (ready_hold > 0) begin
          mdu_in_ready = 1'b0;
          ready_hold--;
        end else begin
          mdu_in_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever an issue handshake or an unstalled read occurs
  always @(negedge clk) begin
    if (!reset) begin
      if (mdu_in_valid && mdu_in_ready) begin
        if (issue_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_issue: got op=%0d sign=%0d expected no issue", mdu_op, mdu_sign);
        end else begin
          check("issue", {mdu_op, mdu_sign, mdu_src0, mdu_src1}, issue_q.pop_front());
        end
      end
      if ((e_md_op == 4'd7 || e_md_op == 4'd8) && !md_stall) begin
        if (read_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_read: got %h expected no read", md_rdata);
        end else begin
          check(e_md_op == 4'd7 ? "mfhi" : "mflo", {35'd0, md_rdata}, {35'd0, read_q.pop_front()});
        end
      end
    end
  end

  // Present one instruction from posedge+1 and hold it until it is not stalled at negedge
  task automatic exec(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic fl, output int stalls);
    e_md_op = op;
    e_rs    = rs;
    e_rt    = rt;
    e_flush = fl;
    stalls  = 0;
    forever begin
      @(negedge clk);
      if (!md_stall) break;
      stalls++;
      if (stalls > 60) begin
        fail_now("stall_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
    e_md_op = 4'd0;
    e_flush = 1'b0;
  endtask

  task automatic read_hi(input logic [31:0] exp, output int stalls);
    read_q.push_back(exp);
    exec(4'd7, 32'h0, 32'h0, 1'b0, stalls);
  endtask

  task automatic read_lo(input logic [31:0] exp, output int stalls);
    read_q.push_back(exp);
    exec(4'd8, 32'h0, 32'h0, 1'b0, stalls);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [1:0] exp_op, input logic exp_sign,
                       input int lat, input logic [31:0] r1, input logic [31:0] r0,
                       output int stalls);
    lat_cfg = lat;
    r0_cfg  = r0;
    r1_cfg  = r1;
    issue_q.push_back({exp_op, exp_sign, rs, rt});
    exec(op, rs, rt, 1'b0, stalls);
  endtask

  initial begin : stim
    int st;
    reset   = 1'b1;
    e_md_op = 4'd0;
    e_rs    = '0;
    e_rt    = '0;
    e_flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", {66'd0, md_busy}, 67'd0);
    check("rst_stall", {66'd0, md_stall}, 67'd0);
    check("rst_in_valid", {66'd0, mdu_in_valid}, 67'd0);
    check("rst_out_ready", {66'd0, mdu_out_ready}, 67'd0);
    check("rst_mdu_op", {65'd0, mdu_op}, 67'd0);
    @(posedge clk);
    #1;
    read_hi(RST_HI, st);
    read_lo(RST_LO, st);

    // mult -1 * 2, 1-cycle MDU
    issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 1'b1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, st);
    check("mult_issue_stall", 67'(st), 67'd0);
    read_hi(32'hFFFF_FFFF, st);
    check("mfhi_after_mult_stall", 67'(st), 67'd1);
    read_lo(32'hFFFF_FFFE, st);

    // multu same operands, MDU not ready for two cycles
    ready_hold = 2;
    issue(4'd2, 32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 1'b0, 1, 32'h0000_0001, 32'hFFFF_FFFE, st);
    check("multu_not_ready_stall", 67'(st), 67'd2);
    read_hi(32'h0000_0001, st);
    read_lo(32'hFFFF_FFFE, st);

    // div -7 / 2, 4-cycle MDU; mflo follows immediately
    issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 2'b10, 1'b1, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFD, st);
    read_lo(32'hFFFF_FFFD, st);
    check("mflo_after_div_stall", 67'(st), 67'd4);
    read_hi(32'hFFFF_FFFF, st);

    // Flushed div: no issue, stays idle
    e_md_op = 4'd3;
    e_rs    = 32'h0000_0010;
    e_rt    = 32'h0000_0003;
    e_flush = 1'b1;
    @(negedge clk);
    check("flush_in_valid", {66'd0, mdu_in_valid}, 67'd0);
    check("flush_stall", {66'd0, md_stall}, 67'd0);
    @(posedge clk);
    #1;
    e_md_op = 4'd0;
    e_flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {66'd0, md_busy}, 67'd0);
    @(posedge clk);
    #1;
    read_hi(32'hFFFF_FFFF, st);
    read_lo(32'hFFFF_FFFD, st);

    // divu 100/7 then mthi while busy: mthi waits, then wins
    issue(4'd4, 32'd100, 32'd7, 2'b10, 1'b0, 3, 32'd2, 32'd14, st);
    exec(4'd5, 32'h1234_5678, 32'h0, 1'b0, st);
    check("mthi_busy_stall", 67'(st), 67'd3);
    read_hi(32'h1234_5678, st);
    read_lo(32'd14, st);

    // mtlo flushed is dropped, unflushed mtlo lands
    exec(4'd6, 32'hDEAD_BEEF, 32'h0, 1'b1, st);
    read_lo(32'd14, st);
    exec(4'd6, 32'hCAFE_F00D, 32'h0, 1'b0, st);
    read_lo(32'hCAFE_F00D, st);
    read_hi(32'h1234_5678, st);

    // Divide by zero: HI/LO take whatever the MDU returns
    issue(4'd3, 32'h0000_0005, 32'h0, 2'b10, 1'b1, 2, 32'h0000_0005, 32'hFFFF_FFFF, st);
    read_hi(32'h0000_0005, st);
    read_lo(32'hFFFF_FFFF, st);

    // Reset in the middle of a long div
    issue(4'd3, 32'd9, 32'd3, 2'b10, 1'b1, 6, 32'h1111_1111, 32'h2222_2222, st);
    @(negedge clk);
    check("busy_before_reset", {66'd0, md_busy}, 67'd1);
    @(posedge clk);
    #3;
    reset   = 1'b1;
    e_md_op = 4'd7;
    #1;
    check("async_rst_busy", {66'd0, md_busy}, 67'd0);
    check("async_rst_hi", {35'd0, md_rdata}, {35'd0, RST_HI});
    e_md_op = 4'd8;
    #1;
    check("async_rst_lo", {35'd0, md_rdata}, {35'd0, RST_LO});
    e_md_op = 4'd0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    check("post_rst_out_ready", {66'd0, mdu_out_ready}, 67'd0);
    @(posedge clk);
    #1;
    read_hi(RST_HI, st);
    read_lo(RST_LO, st);

    repeat (2) @(posedge clk);
    check("issue_q_drained", 67'(issue_q.size()), 67'd0);
    check("read_q_drained", 67'(read_q.size()), 67'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
